// File: rtl/ntt_pkg.sv
// Shared types and constants for the matrix-vector NTT/INTT engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ntt_pkg;

  localparam int W_DEFAULT    = 12;
  localparam int Q_DEFAULT    = 3329;
  localparam int NINV_DEFAULT = 3303;  // 128^-1 mod 3329

  typedef logic [W_DEFAULT-1:0] coeff_t;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_SCALE,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ntt_mv_engine_mod_mac.sv
// One modular MAC lane: registered (a*b mod Q) stage feeding a mod-Q accumulator, plus clear and n^-1 scale.
// Latency: product registered 1 cycle after vld_i, folded into acc_o the cycle after that.
// Backpressure: none; the lane accepts one product per cycle whenever vld_i is high.
// Ports: clk_i/rst_ni clock and async reset; vld_i qualifies a_i/b_i; clr_i zeroes the accumulator;
//        scale_i multiplies the accumulator by NINV mod Q; acc_o is the current accumulator (< Q).
module mod_mac #(
  parameter int W    = 12,
  parameter int Q    = 3329,
  parameter int NINV = 3303
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         vld_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         clr_i,
  input  logic         scale_i,
  output logic [W-1:0] acc_o
);

  localparam logic [2*W-1:0] Q_2W   = (2*W)'(Q);
  localparam logic [W:0]     Q_1W   = (W+1)'(Q);
  localparam logic [W-1:0]   NINV_W = W'(NINV);

  logic [2*W-1:0] prod;
  logic [2*W-1:0] sprod;
  logic [W:0]     sum;
  logic [W-1:0]   p_q;
  logic           p_vld_q;
  logic [W-1:0]   acc_q;

  // Full-width products: inputs may be >= Q, so reduce the whole 2W-bit value.
  assign prod  = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
  assign sprod = {{W{1'b0}}, acc_q} * {{W{1'b0}}, NINV_W};
  // Both operands are < Q, so one conditional subtract keeps the sum < Q.
  assign sum   = {1'b0, acc_q} + {1'b0, p_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_q     <= '0;
      p_vld_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      p_q     <= W'(prod % Q_2W);
      p_vld_q <= vld_i;
      if (clr_i) begin
        acc_q <= '0;
      end else if (scale_i) begin
        acc_q <= W'(sprod % Q_2W);
      end else if (p_vld_q) begin
        acc_q <= (sum >= Q_1W) ? W'(sum - Q_1W) : W'(sum);
      end
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ntt_mv_engine.sv
// Matrix-vector NTT/INTT: out[2r+e] = sum_c A[r][c]*in[2c+e] mod Q, LANES rows per group, 2 MAC lanes per row.
// Latency: (HALF/LANES)*(HALF+3+mode)+1 cycles from accepted start to done_o.
// Backpressure: none; start_i is ignored unless IDLE, the twiddle ROM must answer exactly 1 cycle after tw_req_o.
// Ports: start_i/mode_i request a run; busy_o/done_o report progress; coeff_i is held stable while busy;
//        coeff_o holds results until the next accepted start; tw_* address the external twiddle ROM.
module ntt_mv_engine
  import ntt_pkg::*;
#(
  parameter  int N     = 256,
  parameter  int W     = W_DEFAULT,
  parameter  int Q     = Q_DEFAULT,
  parameter  int LANES = 2,
  parameter  int NINV  = NINV_DEFAULT,
  localparam int HALF  = N / 2,
  localparam int ROWW  = $clog2(N / 2)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      mode_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic [0:N-1][W-1:0]       coeff_i,
  output logic [0:N-1][W-1:0]       coeff_o,
  output logic                      tw_req_o,
  output logic                      tw_mode_o,
  output logic [ROWW-1:0]           tw_row_o,
  output logic [ROWW-1:0]           tw_col_o,
  input  logic [0:LANES-1][W-1:0]   tw_data_i
);

  localparam logic [ROWW-1:0] LAST_COL = ROWW'(HALF - 1);
  localparam logic [ROWW-1:0] LAST_GRP = ROWW'(HALF / LANES - 1);

  state_t          state_q, state_d;
  logic            mode_q;
  logic [ROWW-1:0] g_q;
  logic [ROWW-1:0] c_q;
  logic            drn_q;
  logic            req_d1_q;   // ROM data for the previous request is on tw_data_i
  logic [ROWW-1:0] col_d1_q;   // column that tw_data_i belongs to
  logic            accept;
  logic            mac_clr;
  logic            mac_scale;
  logic [W-1:0]    acc [LANES][2];

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    tw_req_o  = 1'b0;
    mac_clr   = 1'b0;
    mac_scale = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          mac_clr = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy_o   = 1'b1;
        tw_req_o = 1'b1;
        if (c_q == LAST_COL) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        if (drn_q) state_d = (mode_q == MODE_INTT) ? ST_SCALE : ST_WRITE;
      end
      ST_SCALE: begin
        busy_o    = 1'b1;
        mac_scale = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        busy_o  = 1'b1;
        mac_clr = 1'b1;
        state_d = (g_q == LAST_GRP) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_NTT;
      g_q      <= '0;
      c_q      <= '0;
      drn_q    <= 1'b0;
      req_d1_q <= 1'b0;
      col_d1_q <= '0;
      coeff_o  <= '0;
    end else begin
      state_q  <= state_d;
      req_d1_q <= tw_req_o;
      col_d1_q <= c_q;
      if (accept) begin
        mode_q  <= mode_i;
        g_q     <= '0;
        c_q     <= '0;
        drn_q   <= 1'b0;
        coeff_o <= '0;
      end
      if (state_q == ST_ISSUE) c_q <= (c_q == LAST_COL) ? '0 : c_q + 1'b1;
      if (state_q == ST_DRAIN) drn_q <= ~drn_q;
      if (state_q == ST_WRITE) begin
        for (int l = 0; l < LANES; l++) begin
          for (int e = 0; e < 2; e++) begin
            coeff_o[{ROWW'(int'(g_q) * LANES + l), 1'(e)}] <= acc[l][e];
          end
        end
        if (g_q != LAST_GRP) g_q <= g_q + 1'b1;
      end
    end
  end

  assign tw_mode_o = mode_q;
  assign tw_row_o  = ROWW'(int'(g_q) * LANES);
  assign tw_col_o  = c_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar e = 0; e < 2; e++) begin : g_half
      mod_mac #(
        .W   (W),
        .Q   (Q),
        .NINV(NINV)
      ) u_mac (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .vld_i  (req_d1_q),
        .a_i    (tw_data_i[l]),
        .b_i    (coeff_i[{col_d1_q, 1'(e)}]),
        .clr_i  (mac_clr),
        .scale_i(mac_scale),
        .acc_o  (acc[l][e])
      );
    end
  end

endmodule

// File: tb/tb_ntt_mv_engine.sv
`timescale 1ns/1ps
module tb_ntt_mv_engine;

  localparam int N = 256, W = 12, Q = 3329, LANES = 2, HALF = 128;
  localparam int SN = 64, SW = 5, SQ = 17, SL = 4, SH = 32, SNINV = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start, mode, busy, done, tw_req, tw_mode;
  logic [6:0] tw_row, tw_col;
  logic [0:N-1][W-1:0] cin, cout;
  logic [0:LANES-1][W-1:0] tw_data;

  logic s_start, s_mode, s_busy, s_done, s_req, s_twmode;
  logic [4:0] s_row, s_col;
  logic [0:SN-1][SW-1:0] s_cin, s_cout;
  logic [0:SL-1][SW-1:0] s_tw;

  int rom_sel;
  int checks, errors;

  ntt_mv_engine dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode),
    .busy_o(busy), .done_o(done), .coeff_i(cin), .coeff_o(cout),
    .tw_req_o(tw_req), .tw_mode_o(tw_mode), .tw_row_o(tw_row), .tw_col_o(tw_col),
    .tw_data_i(tw_data)
  );

  ntt_mv_engine #(.N(SN), .W(SW), .Q(SQ), .LANES(SL), .NINV(SNINV)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .mode_i(s_mode),
    .busy_o(s_busy), .done_o(s_done), .coeff_i(s_cin), .coeff_o(s_cout),
    .tw_req_o(s_req), .tw_mode_o(s_twmode), .tw_row_o(s_row), .tw_col_o(s_col),
    .tw_data_i(s_tw)
  );

  function automatic int rom_val(int r, int c);
    if (rom_sel == 1) return (r + c) % Q;
    return 1;
  endfunction

  function automatic int s_rom(int r, int c, int m);
    return (3 * r + 5 * c + 1 + 7 * m) % 32;
  endfunction

  always @(posedge clk) begin
    if (tw_req === 1'b1)
      for (int l = 0; l < LANES; l++) tw_data[l] <= W'(rom_val(int'(tw_row) + l, int'(tw_col)));
    if (s_req === 1'b1)
      for (int l = 0; l < SL; l++) s_tw[l] <= SW'(s_rom(int'(s_row) + l, int'(s_col), int'(s_twmode)));
  end

  // Called at #1 after a posedge in IDLE; returns #1 after the accepting edge (cycle 1).
  task automatic kick(input logic m);
    mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m;
  endtask

  // Runs from cycle 1 until done_o, pulsing start_i at cycles pa/pb, tracking ROM addressing.
  task automatic wait_done(input int pa, input int pb, input logic m,
                           output int dcyc, output int nreq, output int bad);
    int cyc, ec, er;
    cyc = 1; ec = 0; er = 0; nreq = 0; bad = 0; dcyc = -1;
    while (cyc < 20000) begin
      start = (cyc == pa || cyc == pb);
      if (done === 1'b1) begin
        dcyc = cyc;
        if (busy !== 1'b0 || tw_req !== 1'b0) bad++;
        break;
      end
      if (busy !== 1'b1 || tw_mode !== m) bad++;
      if (tw_req === 1'b1) begin
        if (int'(tw_col) != ec || int'(tw_row) != er) bad++;
        nreq++; ec++;
        if (ec == HALF) begin ec = 0; er += LANES; end
      end
      @(posedge clk); #1; cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int nbad, dcyc, nreq, bad;
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({busy, done, tw_req, tw_mode} !== 4'b0 || tw_row !== 7'd0 || tw_col !== 7'd0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b done=%b req=%b mode=%b row=%0d col=%0d required all 0",
                         busy, done, tw_req, tw_mode, tw_row, tw_col);
    end
    checks++;
    if (cout !== '0 || s_cout !== '0) begin errors++; $display("FAIL reset_coeff: coeff_o not all 0"); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) cin[i] = W'(1);
    rom_sel = 0;
    kick(1'b0);
    repeat (282) @(posedge clk); #1;   // cycle 283: group 2 ISSUE
    checks++;
    if (tw_req !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_issue: got req=%b busy=%b required 1 1", tw_req, busy);
    end
    checks++;
    if (cout[0] !== W'(128) || cout[3] !== W'(128)) begin
      errors++; $display("FAIL mid_partial: got %0d %0d required 128 128", cout[0], cout[3]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, tw_req} !== 3'b0) begin
      errors++; $display("FAIL async_reset_outputs: got busy=%b done=%b req=%b required 0", busy, done, tw_req);
    end
    checks++;
    if (cout !== '0) begin errors++; $display("FAIL async_reset_coeff: coeff_o not zeroed"); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    kick(1'b0);
    wait_done(0, 0, 1'b0, dcyc, nreq, bad);
    checks++;
    if (dcyc != 8385) begin errors++; $display("FAIL post_reset_latency: got %0d required 8385", dcyc); end
    nbad = 0;
    for (int i = 0; i < N; i++) if (cout[i] !== W'(128)) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL post_reset_coeff: got %0d wrong required 0", nbad); end
    @(posedge clk); #1;
  endtask

  task automatic test_unity_ntt();
    int nbad, dcyc, nreq, bad, extra;
    for (int i = 0; i < N; i++) cin[i] = W'(1);
    rom_sel = 0;
    kick(1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_cycle1: got %b required 1", busy); end
    wait_done(0, 0, 1'b0, dcyc, nreq, bad);
    checks++;
    if (dcyc != 8385) begin errors++; $display("FAIL unity_latency: got %0d required 8385", dcyc); end
    checks++;
    if (nreq != 8192 || bad != 0) begin
      errors++; $display("FAIL unity_rom_seq: got req=%0d bad=%0d required 8192 0", nreq, bad);
    end
    nbad = 0;
    for (int i = 0; i < N; i++) if (cout[i] !== W'(128)) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL unity_coeff: got %0d wrong required 0", nbad); end
    extra = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || tw_req !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL unity_idle_after: got %0d bad cycles required 0", extra); end
  endtask

  task automatic test_wrap_ntt();
    int nbad, dcyc, nreq, bad;
    for (int i = 0; i < N; i++) cin[i] = W'(3328);
    kick(1'b0);
    wait_done(0, 0, 1'b0, dcyc, nreq, bad);
    nbad = 0;
    for (int i = 0; i < N; i++) if (cout[i] !== W'(3201)) nbad++;
    checks++;
    if (nbad != 0 || dcyc != 8385) begin
      errors++; $display("FAIL wrap_coeff: got %0d wrong, done at %0d required 0, 8385", nbad, dcyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_intt();
    int nbad, dcyc, nreq, bad;
    for (int i = 0; i < N; i++) cin[i] = W'(1);
    kick(1'b1);
    wait_done(0, 0, 1'b1, dcyc, nreq, bad);
    checks++;
    if (dcyc != 8449) begin errors++; $display("FAIL intt_latency: got %0d required 8449", dcyc); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL intt_mode_seq: got %0d bad cycles required 0", bad); end
    nbad = 0;
    for (int i = 0; i < N; i++) if (cout[i] !== W'(1)) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL intt_coeff: got %0d wrong required 0", nbad); end
    @(posedge clk); #1;
  endtask

  task automatic test_delta();
    int nbad, dcyc, nreq, bad;
    cin = '0; cin[0] = W'(1);
    rom_sel = 1;
    kick(1'b0);
    wait_done(0, 0, 1'b0, dcyc, nreq, bad);
    checks++;
    if (bad != 0 || nreq != 8192) begin
      errors++; $display("FAIL delta_col_seq: got bad=%0d req=%0d required 0 8192", bad, nreq);
    end
    nbad = 0;
    for (int r = 0; r < HALF; r++) begin
      if (cout[2*r] !== W'(r)) nbad++;
      if (cout[2*r+1] !== W'(0)) nbad++;
    end
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL delta_coeff: got %0d wrong required 0", nbad); end
    rom_sel = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int nbad, dcyc, nreq, bad;
    for (int i = 0; i < N; i++) cin[i] = W'(2);
    kick(1'b0);
    wait_done(5, 8000, 1'b0, dcyc, nreq, bad);
    checks++;
    if (dcyc != 8385) begin errors++; $display("FAIL busy_start_ignored: done at %0d required 8385", dcyc); end
    nbad = 0;
    for (int i = 0; i < N; i++) if (cout[i] !== W'(256)) nbad++;
    checks++;
    if (nbad != 0) begin errors++; $display("FAIL busy_start_coeff: got %0d wrong required 0", nbad); end
    mode = 1'b1; start = 1'b1;            // in the DONE cycle: must be ignored
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_cycle_start: got busy=%b required 0", busy); end
    @(posedge clk); #1;                   // first IDLE cycle start accepted
    start = 1'b0; mode = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL idle_restart: got busy=%b required 1", busy); end
    wait_done(0, 0, 1'b1, dcyc, nreq, bad);
    nbad = 0;
    for (int i = 0; i < N; i++) if (cout[i] !== W'(2)) nbad++;
    checks++;
    if (nbad != 0 || dcyc != 8449) begin
      errors++; $display("FAIL restart_run: got %0d wrong, done at %0d required 0, 8449", nbad, dcyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_param_sweep();
    int exp_c [SN];
    int acc, cyc, nbad;
    for (int it = 0; it < 4; it++) begin
      logic m;
      m = it[0];
      for (int i = 0; i < SN; i++) s_cin[i] = SW'($urandom_range(0, 31));
      for (int r = 0; r < SH; r++)
        for (int e = 0; e < 2; e++) begin
          acc = 0;
          for (int c = 0; c < SH; c++) acc = (acc + s_rom(r, c, int'(m)) * int'(s_cin[2*c+e])) % SQ;
          if (m) acc = (acc * SNINV) % SQ;
          exp_c[2*r+e] = acc;
        end
      s_mode = m; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0; s_mode = ~m;
      cyc = 1;
      while (cyc < 2000 && s_done !== 1'b1) begin @(posedge clk); #1; cyc++; end
      checks++;
      if (cyc != 8 * (SH + 3 + int'(m)) + 1) begin
        errors++; $display("FAIL sweep_latency[%0d]: got %0d required %0d", it, cyc, 8 * (SH + 3 + int'(m)) + 1);
      end
      nbad = 0;
      for (int i = 0; i < SN; i++) if (s_cout[i] !== SW'(exp_c[i])) nbad++;
      checks++;
      if (nbad != 0) begin errors++; $display("FAIL sweep_coeff[%0d]: got %0d wrong required 0", it, nbad); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; s_start = 1'b0; s_mode = 1'b0;
    rom_sel = 0; cin = '0; s_cin = '0;
    test_reset();
    test_unity_ntt();
    test_wrap_ntt();
    test_intt();
    test_delta();
    test_back_to_back();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
